// File: rtl/flash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flash_pkg
// Description : Shared constants for the SPI flash read path: address width,
//               read opcode, arbiter state encoding and round-robin helper.
// Revision    : 1.0 - initial release
// ============================================================================
package flash_pkg;

  localparam int FLASH_ADDR_WIDTH = 24;
  localparam logic [7:0] READ_COMMAND = 8'h03;

  // Arbiter scheduler states
  localparam int ARB_STATE_W = 2;
  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ISSUE  = 2'd1;
  localparam logic [1:0] ARB_STREAM = 2'd2;

  // Two-way round-robin pick: on contention the port that did not win last
  // time goes next; otherwise the sole requester wins (port 0 when idle).
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last);
    return (req0 && req1) ? ~last : req1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin arbiter. Grant is combinational;
//               the remembered winner only moves when the caller advances.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import flash_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic grant,
  output logic grant_valid
);

  // Port 1 counts as the last winner out of reset so port 0 wins first tie.
  logic last_grant;

  // Combinational grant from current requests and the last winner
  always_comb begin
    grant_valid = req0 | req1;
    grant       = rr_pick(req0, req1, last_grant);
  end

  // Remember the winner whenever the grant is actually consumed
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= grant;
    end
  end

endmodule
`default_nettype wire

// File: rtl/flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : flash_read_arbiter
// Description : Schedules whole read transactions from two requesters onto
//               one SPI flash read engine and routes bytes / completion back
//               to the owning port. Flags engine protocol violations.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_read_arbiter
  import flash_pkg::*;
#(
  parameter int ADDR_WIDTH = FLASH_ADDR_WIDTH,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  // requester 0
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [LEN_WIDTH-1:0]  req0_len,
  output logic [7:0]            req0_data,
  output logic                  req0_data_valid,
  output logic                  req0_done,
  // requester 1
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [LEN_WIDTH-1:0]  req1_len,
  output logic [7:0]            req1_data,
  output logic                  req1_data_valid,
  output logic                  req1_done,
  // engine
  output logic                  eng_valid,
  input  logic                  eng_ready,
  output logic [ADDR_WIDTH-1:0] eng_addr,
  output logic [LEN_WIDTH-1:0]  eng_len,
  input  logic [7:0]            eng_data,
  input  logic                  eng_data_valid,
  input  logic                  eng_done,
  // status
  output logic                  busy,
  output logic                  proto_err
);

  logic [ARB_STATE_W-1:0] state;
  logic                   owner;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   byte_cnt;
  logic [7:0]             data_q;
  logic                   dv0_q;
  logic                   dv1_q;
  logic                   done0_q;
  logic                   done1_q;
  logic                   perr_q;

  logic                   grant;
  logic                   grant_valid;
  logic                   accept;
  logic                   idle_open;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [LEN_WIDTH-1:0]   sel_len;
  logic                   in_stream;
  logic                   byte_ok;
  logic [LEN_WIDTH-1:0]   cnt_next;
  logic                   err_event;

  rr_arbiter2 u_arb (
    .clock       (clock),
    .reset       (reset),
    .req0        (req0_valid),
    .req1        (req1_valid),
    .advance     (accept),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Request handshake and selection of the winning port's command
  always_comb begin
    // Ready is masked during reset so every output reads 0 while it is held.
    idle_open  = (state == ARB_IDLE) && !reset;
    req0_ready = idle_open && grant_valid && !grant && req0_valid;
    req1_ready = idle_open && grant_valid &&  grant && req1_valid;
    accept     = req0_ready | req1_ready;
    sel_addr   = grant ? req1_addr : req0_addr;
    sel_len    = grant ? req1_len  : req0_len;
  end

  // Byte acceptance, running count and protocol-violation detection
  always_comb begin
    in_stream = (state == ARB_STREAM);
    // Bytes beyond the requested length are dropped, never forwarded.
    byte_ok   = in_stream && eng_data_valid && (byte_cnt != len_q);
    cnt_next  = byte_cnt + LEN_WIDTH'(byte_ok);
    // A byte arriving together with done counts toward the length check.
    err_event = (eng_data_valid && !in_stream)
              || (in_stream && eng_data_valid && (byte_cnt == len_q))
              || (in_stream && eng_done && (cnt_next != len_q));
  end

  // Output drive: engine command only while issuing, status from state
  always_comb begin
    eng_valid       = (state == ARB_ISSUE);
    eng_addr        = eng_valid ? addr_q : '0;
    eng_len         = eng_valid ? len_q  : '0;
    busy            = (state != ARB_IDLE);
    proto_err       = perr_q;
    req0_data       = data_q;
    req1_data       = data_q;
    req0_data_valid = dv0_q;
    req1_data_valid = dv1_q;
    req0_done       = done0_q;
    req1_done       = done1_q;
  end

  // Scheduler FSM: accept a transaction, issue it, stream until done
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ARB_IDLE;
      owner    <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (accept) begin
            owner  <= grant;
            addr_q <= sel_addr;
            len_q  <= sel_len;
            // Zero-length reads complete without touching the engine.
            if (sel_len != '0) begin
              state <= ARB_ISSUE;
            end
          end
        end
        ARB_ISSUE: begin
          if (eng_ready) begin
            state    <= ARB_STREAM;
            byte_cnt <= '0;
          end
        end
        ARB_STREAM: begin
          byte_cnt <= cnt_next;
          if (eng_done) begin
            state <= ARB_IDLE;
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Registered routing of byte strobes, data and completion to the owner
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      dv0_q   <= 1'b0;
      dv1_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      dv0_q   <= byte_ok && !owner;
      dv1_q   <= byte_ok &&  owner;
      if (byte_ok) begin
        data_q <= eng_data;
      end
      done0_q <= (accept && !grant && (sel_len == '0))
               || (in_stream && eng_done && !owner);
      done1_q <= (accept &&  grant && (sel_len == '0))
               || (in_stream && eng_done &&  owner);
    end
  end

  // Sticky protocol error flag, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else if (err_event) begin
      perr_q <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/flash_read_arbiter.md
# flash_read_arbiter

Shares one SPI flash read engine between two byte-stream requesters (e.g. instruction fetch and data load of the CPU). Accepts whole read transactions (start address plus byte count) on two request ports and arbitrates them round-robin. Issues the winner's command to the engine, then routes returned bytes and the completion pulse back to the owning port. The engine performs all SPI sequencing; this block only schedules it.

## Interface
- ADDR_WIDTH, 24, flash byte address width
- LEN_WIDTH, 16, byte-count width per transaction
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- reqN_valid  in  1  (N=0,1) transaction request
- reqN_ready  out  1  request accepted this cycle when valid&ready
- reqN_addr  in  ADDR_WIDTH  start address
- reqN_len  in  LEN_WIDTH  bytes to read; 0 legal
- reqN_data  out  8  returned byte
- reqN_data_valid  out  1  one-cycle strobe per byte
- reqN_done  out  1  one-cycle pulse, transaction complete
- eng_valid  out  1  command to engine
- eng_ready  in  1  engine accepts command
- eng_addr  out  ADDR_WIDTH  command address
- eng_len  out  LEN_WIDTH  command byte count
- eng_data  in  8  byte from engine
- eng_data_valid  in  1  byte strobe
- eng_done  in  1  engine finished command
- busy  out  1  state != IDLE
- proto_err  out  1  sticky engine-protocol error

## Operation
- States: IDLE, ISSUE, STREAM. Reset -> IDLE; owner=0, last_grant=1, byte_cnt=0, proto_err=0, all outputs 0.
- IDLE: grant = sole valid requester; if both valid, the one not equal to last_grant. reqN_ready combinational = (state==IDLE) && grant==N && reqN_valid. Only one ready high per cycle.
- Accept: latch addr, len, owner; last_grant<=owner. len!=0 -> ISSUE; len==0 -> stay IDLE, pulse reqN_done next cycle, no engine command.
- ISSUE: eng_valid=1, eng_addr/eng_len held stable from latched values until eng_valid&eng_ready; then -> STREAM, byte_cnt<=0.
- STREAM: each eng_data_valid forwards eng_data to owner, byte_cnt+1. On eng_done -> IDLE, pulse owner done. Data and done in same cycle: both forwarded.
- Errors (set proto_err, sticky until reset): eng_data_valid outside STREAM (byte dropped); byte_cnt already == len on data strobe (byte dropped); eng_done with byte_cnt != len (done still forwarded).
- Non-owner port never sees data_valid or done.
- Reset mid-transaction: immediate return to IDLE, outputs 0, in-flight command abandoned; engine shares the same reset.

## Timing
- Accept at cycle T -> eng_valid=1 at T+1.
- Engine handshake at U -> STREAM at U+1.
- eng_data_valid at V -> reqN_data_valid/reqN_data registered at V+1.
- eng_done at W -> reqN_done at W+1, state IDLE at W+1; next accept possible at W+1.
- Zero-length accepted at T -> reqN_done at T+1; next accept at T+1.
- Minimum back-to-back: one transaction per (engine latency + 2) cycles.
- byte_cnt width LEN_WIDTH; no wrap (len bounded by LEN_WIDTH).

## Structure
- Shared package flash_pkg: FLASH_ADDR_WIDTH=24, READ_COMMAND=8'h03, arbiter state localparams (IDLE=0, ISSUE=1, STREAM=2); engine and arbiter both import it.
- One sub-module: rr_arbiter2 (two request inputs, last_grant register, grant output, advance input); FSM and routing stay in flash_read_arbiter.

## Test plan
- Single req0 addr=24'h100000 len=4, engine returns AA,BB,CC,DD -> eng_addr=100000/len=4 at T+1; req0 sees 4 strobes AA..DD one cycle late, done once, req1 silent.
- req0 and req1 valid same cycle, held for 3 transactions each -> grant order 0,1,0,1,0,1.
- req1 len=0 -> req1_done at T+1, eng_valid never asserted, proto_err=0.
- eng_ready held low 10 cycles -> eng_valid, eng_addr, eng_len stable all 10 cycles; transaction then completes normally.
- Engine returns 3 bytes for len=4 then done -> done forwarded, proto_err=1 and stays 1; extra eng_data_valid in IDLE dropped.
- reset pulsed mid-STREAM after 2 of 4 bytes -> busy=0, all outputs 0 same cycle; subsequent req0 transaction completes correctly.
